data_bank_write_arbiter: RTL

//  Owns the single write port of each data-array bank (N_BANK banks; each bank holds WAYS ways x 2^SET_W sets x DATA_W bits).

---
 rtl/data_bank_write_arbiter_pkg.sv | 58 +++++
 rtl/data_bank_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bank_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_bank_write_arbiter_pkg
//
// Purpose:
//   Shared configuration and types for the data-array bank write arbiter.
//   The geometry of the data array lives here. The registered write bundle
//   is a packed struct whose field widths follow this geometry, so the
//   package is the single place where the array shape is changed.
//
// Contents:
//   - Geometry: N_BANK, SET_W, WAYS, DATA_W, MASK_W, BANK_IDX_W.
//   - Arbitration: MAX_STALL and the width of the stall counter.
//   - FULL_MASK: the byte mask used for refill beats.
//   - arb_state_e: the arbiter FSM states.
//   - bank_wr_t: the registered per-cycle bank write bundle.
//   - bank_onehot(): converts a bank index into a one-hot bank enable.
// ---------------------------------------------------------------------------
package data_bank_write_arbiter_pkg;

  // Array geometry. N_BANK must be a power of two and at least 2.
  localparam int N_BANK     = 8;
  localparam int SET_W      = 8;
  localparam int WAYS       = 4;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = DATA_W / 8;
  localparam int BANK_IDX_W = $clog2(N_BANK);

  // Number of cycles a store may wait during a refill before it steals a
  // beat slot. Must be at least 1.
  localparam int MAX_STALL  = 4;
  localparam int STALL_W    = $clog2(MAX_STALL + 1);

  localparam logic [MASK_W-1:0] FULL_MASK = {MASK_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // One registered bank write. The en field is one-hot (or zero when there
  // is no write). The other fields are shared by all banks.
  typedef struct packed {
    logic [N_BANK-1:0] en;
    logic [SET_W-1:0]  set;
    logic [WAYS-1:0]   way;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } bank_wr_t;

  function automatic logic [N_BANK-1:0] bank_onehot(input logic [BANK_IDX_W-1:0] idx);
    logic [N_BANK-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/data_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// data_bank_write_arbiter
//
// Purpose:
//   Owns the single write port of every data-array bank. The module does
//   three things:
//   - It sequences a multi-beat line refill into consecutive banks.
//     Beat k is written to bank k.
//   - It arbitrates refill beats against single-word CPU stores.
//   - It drives one registered write bundle per cycle. The write appears on
//     bank_w_* the cycle after the accepting handshake.
//   refill_busy and refill_set let the read side block hits on the line that
//   is being filled.
//
// Ports:
//   clock, reset        clock and synchronous active-low reset (0 = reset)
//   refill_req_*        refill request (valid/ready). Set and one-hot way
//                       are latched on acceptance; ready is high only in IDLE
//   beat_valid/ready    refill beat handshake; beat_data is the beat word
//   refill_done         one-cycle pulse in DONE, after the last beat write
//                       has been issued
//   refill_busy         high while in REFILL
//   refill_set          latched refill set
//   st_*                store request: set, one-hot way, bank, data and
//                       byte mask, with a valid/ready handshake
//   bank_w_*            registered write: one-hot bank enable, plus the
//                       shared set, way, data and mask
// ---------------------------------------------------------------------------
module data_bank_write_arbiter
  import data_bank_write_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  refill_req_valid,
  output logic                  refill_req_ready,
  input  logic [SET_W-1:0]      refill_req_set,
  input  logic [WAYS-1:0]       refill_req_way,

  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [DATA_W-1:0]     beat_data,

  output logic                  refill_done,
  output logic                  refill_busy,
  output logic [SET_W-1:0]      refill_set,

  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [SET_W-1:0]      st_set,
  input  logic [WAYS-1:0]       st_way,
  input  logic [BANK_IDX_W-1:0] st_bank,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [MASK_W-1:0]     st_mask,

  output logic [N_BANK-1:0]     bank_w_en,
  output logic [SET_W-1:0]      bank_w_set,
  output logic [WAYS-1:0]       bank_w_way,
  output logic [DATA_W-1:0]     bank_w_data,
  output logic [MASK_W-1:0]     bank_w_mask
);

  arb_state_e            state_q;
  logic [BANK_IDX_W-1:0] beat_cnt_q;
  logic [STALL_W-1:0]    stall_cnt_q;
  logic [SET_W-1:0]      refill_set_q;
  logic [WAYS-1:0]       refill_way_q;
  logic                  refill_req_ready_q;
  logic                  refill_busy_q;
  logic                  refill_done_q;

  bank_wr_t              wr_q;
  bank_wr_t              wr_d;

  logic                  st_hazard;
  logic                  stall_full;
  logic                  steal;
  logic                  last_beat;
  logic                  st_ready_c;
  logic                  beat_ready_c;
  logic                  st_fire;
  logic                  beat_fire;
  logic                  req_fire;

  // A store to the line that is being filled must wait until the whole line
  // has been written. Otherwise a later refill beat would overwrite it.
  assign st_hazard  = (st_set == refill_set_q) && (st_way == refill_way_q);
  assign stall_full = (stall_cnt_q == STALL_W'(MAX_STALL));

  // A long-waiting store takes one beat slot from the refill. A store that
  // conflicts with the line never steals, however long it has waited.
  assign steal      = (state_q == REFILL) && st_valid && !st_hazard && stall_full;
  assign last_beat  = (beat_cnt_q == BANK_IDX_W'(N_BANK - 1));

  // The ready signals are forced low while reset is asserted. A handshake
  // in that cycle would be discarded anyway.
  always_comb begin
    st_ready_c   = 1'b0;
    beat_ready_c = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE, DONE: st_ready_c = 1'b1;
        REFILL: begin
          st_ready_c   = steal;
          beat_ready_c = !steal;
        end
        default: begin
          st_ready_c   = 1'b0;
          beat_ready_c = 1'b0;
        end
      endcase
    end
  end

  assign st_fire   = st_valid && st_ready_c;
  assign beat_fire = beat_valid && beat_ready_c;
  assign req_fire  = refill_req_valid && refill_req_ready_q;

  // The next write bundle. Stores and beats are never accepted in the same
  // cycle: in IDLE and DONE beat_ready is low, and in REFILL a steal drops
  // beat_ready. The shared fields hold their value when there is no write,
  // so they do not toggle needlessly.
  always_comb begin
    wr_d    = wr_q;
    wr_d.en = '0;
    if (st_fire) begin
      wr_d.en   = bank_onehot(st_bank);
      wr_d.set  = st_set;
      wr_d.way  = st_way;
      wr_d.data = st_data;
      wr_d.mask = st_mask;
    end else if (beat_fire) begin
      wr_d.en   = bank_onehot(beat_cnt_q);
      wr_d.set  = refill_set_q;
      wr_d.way  = refill_way_q;
      wr_d.data = beat_data;
      wr_d.mask = FULL_MASK;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= IDLE;
      beat_cnt_q         <= '0;
      stall_cnt_q        <= '0;
      refill_set_q       <= '0;
      refill_way_q       <= '0;
      refill_req_ready_q <= 1'b1;
      refill_busy_q      <= 1'b0;
      refill_done_q      <= 1'b0;
      wr_q               <= '0;
    end else begin
      wr_q <= wr_d;
      case (state_q)
        IDLE: begin
          // A store in this same cycle is also accepted. The first beat
          // write cannot be issued before the next cycle, so the write port
          // is free for the store.
          if (req_fire) begin
            state_q            <= REFILL;
            refill_set_q       <= refill_req_set;
            refill_way_q       <= refill_req_way;
            beat_cnt_q         <= '0;
            stall_cnt_q        <= '0;
            refill_req_ready_q <= 1'b0;
            refill_busy_q      <= 1'b1;
          end
        end
        REFILL: begin
          if (beat_fire && last_beat) begin
            state_q       <= DONE;
            stall_cnt_q   <= '0;
            refill_busy_q <= 1'b0;
            refill_done_q <= 1'b1;
          end else begin
            if (beat_fire) begin
              beat_cnt_q <= beat_cnt_q + BANK_IDX_W'(1);
            end
            // The stall count saturates at MAX_STALL. This limit matters
            // only for a store that conflicts with the line, because such a
            // store is never granted here.
            if (st_fire) begin
              stall_cnt_q <= '0;
            end else if (st_valid && !stall_full) begin
              stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
          end
        end
        DONE: begin
          state_q            <= IDLE;
          refill_done_q      <= 1'b0;
          refill_req_ready_q <= 1'b1;
        end
        default: begin
          state_q            <= IDLE;
          refill_busy_q      <= 1'b0;
          refill_done_q      <= 1'b0;
          refill_req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign refill_req_ready = refill_req_ready_q;
  assign beat_ready       = beat_ready_c;
  assign st_ready         = st_ready_c;
  assign refill_done      = refill_done_q;
  assign refill_busy      = refill_busy_q;
  assign refill_set       = refill_set_q;

  assign bank_w_en        = wr_q.en;
  assign bank_w_set       = wr_q.set;
  assign bank_w_way       = wr_q.way;
  assign bank_w_data      = wr_q.data;
  assign bank_w_mask      = wr_q.mask;

endmodule
